cordic_vectoring_iter: RTL and testbench

- Iterative vectoring-mode CORDIC. It is the inverse of the rotation-mode shift/accumulate stages.
- It takes a Cartesian vector (x, y) and drives y to 0.
- It returns the CORDIC-gain-scaled magnitude and the angle atan2(y, x).
- A single shared datapath is reused for ITER cycles behind valid/ready handshakes. It sits between the sample front end and the polar-domain consumers.

---
 rtl/cordic_vectoring_iter.sv | 199 +++++++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: drives y to zero, returning K-scaled magnitude
// and atan2(y, x) as a binary angle, one micro-rotation per cycle on a shared datapath.
`timescale 1ns/1ps

module cordic_vectoring_iter #(
  parameter int W    = 32,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] mag_out,
  output logic [W-1:0] angle_out
);

  localparam int XW = W + 2;
  localparam int CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Table holds 32-bit-scaled constants; rescale to the configured angle width.
  function automatic logic [W-1:0] atan_rom(input logic [CW-1:0] idx);
    logic [31:0] base;
    case (idx)
      5'd0:    base = 32'h20000000;
      5'd1:    base = 32'h12E4051E;
      5'd2:    base = 32'h09FB385B;
      5'd3:    base = 32'h051111D4;
      5'd4:    base = 32'h028B0D43;
      5'd5:    base = 32'h0145D7E1;
      5'd6:    base = 32'h00A2F61E;
      5'd7:    base = 32'h00517C55;
      5'd8:    base = 32'h0028BE53;
      5'd9:    base = 32'h00145F2F;
      5'd10:   base = 32'h000A2F98;
      5'd11:   base = 32'h000517CC;
      5'd12:   base = 32'h00028BE6;
      5'd13:   base = 32'h000145F3;
      5'd14:   base = 32'h0000A2FA;
      5'd15:   base = 32'h0000517D;
      5'd16:   base = 32'h000028BE;
      5'd17:   base = 32'h0000145F;
      5'd18:   base = 32'h00000A30;
      5'd19:   base = 32'h00000518;
      5'd20:   base = 32'h0000028C;
      5'd21:   base = 32'h00000146;
      5'd22:   base = 32'h000000A3;
      5'd23:   base = 32'h00000051;
      5'd24:   base = 32'h00000029;
      5'd25:   base = 32'h00000014;
      5'd26:   base = 32'h0000000A;
      5'd27:   base = 32'h00000005;
      5'd28:   base = 32'h00000003;
      5'd29:   base = 32'h00000001;
      default: base = 32'h00000000;
    endcase
    return W'({base, {W{1'b0}}} >> 32);
  endfunction

  function automatic logic [W-1:0] sat_mag(input logic signed [XW-1:0] v);
    logic [W-1:0] res;
    if (v[XW-1]) begin
      res = {W{1'b0}};
    end else if (v[W:W-1] != 2'b00) begin
      res = {1'b0, {(W-1){1'b1}}};
    end else begin
      res = v[W-1:0];
    end
    return res;
  endfunction

  state_t                state_r, state_next_s;
  logic signed [XW-1:0]  x_r, x_next_s, y_r, y_next_s;
  logic signed [XW-1:0]  x_ext_s, y_ext_s, x_sh_s, y_sh_s;
  logic        [W-1:0]   z_r, z_next_s, atan_s;
  logic        [CW-1:0]  cnt_r, cnt_next_s;
  logic                  in_ready_r, in_ready_next_s;
  logic                  out_valid_r, out_valid_next_s;
  logic        [W-1:0]   mag_r, mag_next_s, angle_r, angle_next_s;

  assign x_ext_s = {{2{x_in[W-1]}}, x_in};
  assign y_ext_s = {{2{y_in[W-1]}}, y_in};
  assign x_sh_s  = x_r >>> cnt_r;
  assign y_sh_s  = y_r >>> cnt_r;
  assign atan_s  = atan_rom(cnt_r);

  // Next-state, datapath and output-register decode.
  always_comb begin
    state_next_s     = state_r;
    x_next_s         = x_r;
    y_next_s         = y_r;
    z_next_s         = z_r;
    cnt_next_s       = cnt_r;
    in_ready_next_s  = in_ready_r;
    out_valid_next_s = out_valid_r;
    mag_next_s       = mag_r;
    angle_next_s     = angle_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready_r) begin
          // Pre-rotate left-half-plane vectors by +/-90 degrees into x >= 0.
          if (!x_in[W-1]) begin
            x_next_s = x_ext_s;
            y_next_s = y_ext_s;
            z_next_s = {W{1'b0}};
          end else if (!y_in[W-1]) begin
            x_next_s = y_ext_s;
            y_next_s = -x_ext_s;
            z_next_s = {2'b01, {(W-2){1'b0}}};
          end else begin
            x_next_s = -y_ext_s;
            y_next_s = x_ext_s;
            z_next_s = {2'b11, {(W-2){1'b0}}};
          end
          cnt_next_s      = {CW{1'b0}};
          in_ready_next_s = 1'b0;
          state_next_s    = S_ITER;
        end else begin
          in_ready_next_s = 1'b1;
        end
      end
      S_ITER: begin
        if (!y_r[XW-1]) begin
          x_next_s = x_r + y_sh_s;
          y_next_s = y_r - x_sh_s;
          z_next_s = z_r + atan_s;
        end else begin
          x_next_s = x_r - y_sh_s;
          y_next_s = y_r + x_sh_s;
          z_next_s = z_r - atan_s;
        end
        if (cnt_r == CW'(ITER - 1)) begin
          cnt_next_s   = {CW{1'b0}};
          state_next_s = S_DONE;
        end else begin
          cnt_next_s   = cnt_r + 5'd1;
        end
      end
      S_DONE: begin
        if (!out_valid_r) begin
          out_valid_next_s = 1'b1;
          mag_next_s       = sat_mag(x_r);
          angle_next_s     = z_r;
        end else if (out_ready) begin
          out_valid_next_s = 1'b0;
          in_ready_next_s  = 1'b1;
          state_next_s     = S_IDLE;
        end else begin
          out_valid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s     = S_IDLE;
        in_ready_next_s  = 1'b1;
        out_valid_next_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      x_r         <= {XW{1'b0}};
      y_r         <= {XW{1'b0}};
      z_r         <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      mag_r       <= {W{1'b0}};
      angle_r     <= {W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      x_r         <= x_next_s;
      y_r         <= y_next_s;
      z_r         <= z_next_s;
      cnt_r       <= cnt_next_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= out_valid_next_s;
      mag_r       <= mag_next_s;
      angle_r     <= angle_next_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign mag_out   = mag_r;
  assign angle_out = angle_r;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed bench for cordic_vectoring_iter: a real-valued reference fills a scoreboard
// at each accept, and results are popped and checked when out_valid appears.
`timescale 1ns/1ps

module tb_cordic_vectoring_iter;

  localparam int W    = 32;
  localparam int ITER = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] mag_out;
  logic [W-1:0] angle_out;

  typedef struct {
    string       tag;
    logic [31:0] exp_mag;
    int          mag_tol;
    logic [31:0] exp_angle;
    bit          chk_angle;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  real  kgain;

  cordic_vectoring_iter #(.W(W), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .angle_out(angle_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                           input int tol);
    logic signed [31:0] d;
    longint ad;
    d  = $signed(obs - exp);
    ad = (d < 0) ? -longint'(d) : longint'(d);
    tests++;
    assert ((ad <= longint'(tol)) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic logic [31:0] ref_mag(input real xr, input real yr);
    return 32'($rtoi(kgain * $sqrt(xr * xr + yr * yr) + 0.5));
  endfunction

  // Present one vector, wait for the accept edge, and record what should come back.
  task automatic send(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                      input logic [31:0] em, input int mt,
                      input logic [31:0] ea, input bit ca);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    x_in = xv;
    y_in = yv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.tag = tag; e.exp_mag = em; e.mag_tol = mt; e.exp_angle = ea; e.chk_angle = ca;
    sb.push_back(e);
  endtask

  task automatic compare_out(input exp_t e, input string sfx);
    if (e.mag_tol == 0) check_eq({e.tag, sfx, "_mag"}, mag_out, e.exp_mag);
    else                check_tol({e.tag, sfx, "_mag"}, mag_out, e.exp_mag, e.mag_tol);
    if (e.chk_angle)    check_tol({e.tag, sfx, "_angle"}, angle_out, e.exp_angle, 32'h6000);
  endtask

  // Wait for a result, check it, optionally hold it under backpressure, then hand it off.
  task automatic collect(input bit chk_lat, input int hold);
    int   cyc = 0;
    exp_t e;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("out_valid_seen", {31'd0, out_valid}, 32'd1);
    if (chk_lat) check_eq("latency", 32'(cyc), 32'(ITER + 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare_out(e, "");
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check_eq({e.tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({e.tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
        compare_out(e, "_hold");
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("handoff_valid", {31'd0, out_valid}, 32'd0);
    check_eq("handoff_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    kgain = 1.0;
    for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mag", mag_out, 32'd0);
    check_eq("rst_angle", angle_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
    end
    check_eq("idle_mag", mag_out, 32'd0);

    // Basic vectors
    send("x_axis", 32'd1000000, 32'd0, ref_mag(1000000.0, 0.0), ITER + 2, 32'h00000000, 1'b1);
    collect(1'b1, 0);
    send("diag", 32'h00100000, 32'h00100000, ref_mag(1048576.0, 1048576.0), ITER + 2,
         32'h20000000, 1'b1);
    collect(1'b1, 0);

    // Quadrants
    send("neg_x", -32'sd1048576, 32'd0, ref_mag(1048576.0, 0.0), ITER + 2, 32'h80000000, 1'b1);
    collect(1'b1, 0);
    send("neg_y", 32'd0, -32'sd1048576, ref_mag(0.0, 1048576.0), ITER + 2, 32'hC0000000, 1'b1);
    collect(1'b1, 0);
    send("q3", -32'sd1048576, -32'sd1048576, ref_mag(1048576.0, 1048576.0), ITER + 2,
         32'hA0000000, 1'b1);
    collect(1'b1, 0);
    send("zero", 32'd0, 32'd0, 32'd0, 0, 32'd0, 1'b0);
    collect(1'b1, 0);

    // Backpressure with an in_valid pulse during iteration
    send("bp", 32'h00100000, 32'h00100000, ref_mag(1048576.0, 1048576.0), ITER + 2,
         32'h20000000, 1'b1);
    repeat (3) @(negedge clk);
    x_in = 32'd5;
    y_in = 32'd7;
    in_valid = 1'b1;
    #1;
    check_eq("bp_busy_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    collect(1'b0, 5);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_no_extra", {31'd0, out_valid}, 32'd0);
    end

    // Saturation and extremes
    send("sat_diag", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h20000000, 1'b1);
    collect(1'b1, 0);
    send("sat_min", 32'h80000000, 32'd0, 32'h7FFFFFFF, 0, 32'h80000000, 1'b1);
    collect(1'b1, 0);

    // Reset in the middle of iterating
    send("mid_rst", 32'd123456, 32'd654321, 32'd0, 0, 32'd0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_mag", mag_out, 32'd0);
    check_eq("midrst_angle", angle_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      check_eq("midrst_no_out", {31'd0, out_valid}, 32'd0);
    end
    send("after_rst", 32'd300000, -32'sd400000, ref_mag(300000.0, 400000.0), ITER + 2,
         32'($rtoi(-0.927295218 / (2.0 * 3.14159265358979) * 4294967296.0)), 1'b1);
    collect(1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
